bju_ckpt: RTL and testbench

Parametrised branch/jump resolution unit for the superscalar back end. It resolves conditional branches, JAL and JALR against the front-end prediction. It also owns a circular queue of `CKPT_DEPTH` global-history (GHSR) checkpoints, one per in-flight branch, so that a misprediction restores the exact GHSR regardless of how many younger branches were predicted after it. Results are registered, one cycle after the resolve request, and feed the fetch redirect and gshare update paths.

---
 rtl/bju_ckpt.sv | 186 ++++++++++++++++++
 tb/tb_bju_ckpt.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bju_ckpt.sv
// Branch/jump resolution unit with a circular queue of global-history checkpoints.
// A misprediction restores the exact history held for the resolving branch.
package bju_pkg;
  typedef struct packed {
    logic       is_branch;
    logic       is_jump;
    logic       is_jumpr;
    logic [2:0] funct3;
  } control_type;
endpackage

module bju_ckpt
  import bju_pkg::*;
#(
  parameter int GHR_W      = 8,
  parameter int CKPT_DEPTH = 4,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               alloc_valid,
  input  logic [GHR_W-1:0]   alloc_ghsr,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               res_valid,
  input  logic [TAG_W-1:0]   res_tag,
  input  logic               flush_valid,
  input  control_type        control,
  input  logic [31:0]        left_operand,
  input  logic [31:0]        right_operand,
  input  logic [31:0]        pc,
  input  logic [31:0]        immediate_data,
  input  logic               pred_taken,
  input  logic               pred_btb_hit,
  input  logic [31:0]        pred_btb_addr,
  output logic               out_valid,
  output logic [31:0]        out_link_pc,
  output logic [31:0]        out_target_pc,
  output logic               out_taken,
  output logic               out_flush,
  output logic               out_update_ghsr,
  output logic [GHR_W-1:0]   out_ghsr_restore,
  output logic               tag_err,
  output logic [TAG_W:0]     ckpt_count
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(CKPT_DEPTH);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [GHR_W-1:0] ckpt_q [CKPT_DEPTH];
  logic [GHR_W-1:0] ckpt_d [CKPT_DEPTH];

  logic             valid_q, valid_d, taken_q, taken_d, flush_q, flush_d;
  logic             upd_q, upd_d, tag_err_q, tag_err_d;
  logic [31:0]      link_q, link_d, target_q, target_d;
  logic [GHR_W-1:0] restore_q, restore_d;

  logic             resolve_s, good_res_s, bad_res_s, taken_s, flush_s, upd_s;
  logic             dir_diff_s, cond_s, full_s;
  logic [31:0]      pc_plus4_s, pc_imm_s, target_s;
  logic [GHR_W-1:0] restore_s;

  // Direction, target and misprediction decision for the current resolve.
  always_comb begin
    pc_plus4_s = pc + 32'd4;
    pc_imm_s   = pc + immediate_data;
    case (control.funct3)
      3'b000:  cond_s = (left_operand == right_operand);
      3'b001:  cond_s = (left_operand != right_operand);
      3'b100:  cond_s = ($signed(left_operand) <  $signed(right_operand));
      3'b101:  cond_s = ($signed(left_operand) >= $signed(right_operand));
      3'b110:  cond_s = (left_operand <  right_operand);
      3'b111:  cond_s = (left_operand >= right_operand);
      default: cond_s = 1'b0;
    endcase
    if (control.is_jumpr) begin
      taken_s  = 1'b1;
      target_s = (left_operand + immediate_data) & 32'hFFFF_FFFE;
    end else if (control.is_jump) begin
      taken_s  = 1'b1;
      target_s = pc_imm_s;
    end else begin
      taken_s  = cond_s;
      target_s = cond_s ? pc_imm_s : pc_plus4_s;
    end
    dir_diff_s = taken_s ^ pred_taken;
    flush_s    = dir_diff_s | (pred_btb_hit & pred_taken & taken_s & (target_s != pred_btb_addr));
    upd_s      = ~pred_btb_hit | dir_diff_s;
    restore_s  = {ckpt_q[head_q][GHR_W-2:0], taken_s};
  end

  // Checkpoint queue bookkeeping and next registered result.
  always_comb begin
    full_s     = (count_q == FULL_CNT);
    resolve_s  = res_valid & (control.is_branch | control.is_jump | control.is_jumpr) & ~flush_valid;
    good_res_s = resolve_s & (res_tag == head_q) & (count_q != '0);
    bad_res_s  = resolve_s & ~good_res_s;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ckpt_d  = ckpt_q;
    if (flush_valid || (good_res_s && flush_s)) begin
      head_d  = tail_q;
      count_d = '0;
    end else if (good_res_s) begin
      head_d = head_q + TAG_W'(1);
      if (alloc_valid) begin
        // The popped slot frees room, so the allocation is taken even when full.
        ckpt_d[tail_q] = alloc_ghsr;
        tail_d         = tail_q + TAG_W'(1);
      end else begin
        count_d = count_q - (TAG_W+1)'(1);
      end
    end else if (alloc_valid && !full_s) begin
      ckpt_d[tail_q] = alloc_ghsr;
      tail_d         = tail_q + TAG_W'(1);
      count_d        = count_q + (TAG_W+1)'(1);
    end else begin
      count_d = count_q;
    end

    valid_d   = good_res_s;
    tag_err_d = bad_res_s;
    if (good_res_s) begin
      link_d    = pc_plus4_s;
      target_d  = target_s;
      taken_d   = taken_s;
      flush_d   = flush_s;
      upd_d     = upd_s;
      restore_d = restore_s;
    end else begin
      link_d    = 32'd0;
      target_d  = 32'd0;
      taken_d   = 1'b0;
      flush_d   = 1'b0;
      upd_d     = 1'b0;
      restore_d = '0;
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) ckpt_q[i] <= '0;
      valid_q   <= 1'b0;
      tag_err_q <= 1'b0;
      link_q    <= 32'd0;
      target_q  <= 32'd0;
      taken_q   <= 1'b0;
      flush_q   <= 1'b0;
      upd_q     <= 1'b0;
      restore_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ckpt_q    <= ckpt_d;
      valid_q   <= valid_d;
      tag_err_q <= tag_err_d;
      link_q    <= link_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      flush_q   <= flush_d;
      upd_q     <= upd_d;
      restore_q <= restore_d;
    end
  end

  assign alloc_ready      = (count_q != FULL_CNT);
  assign alloc_tag        = tail_q;
  assign ckpt_count       = count_q;
  assign out_valid        = valid_q;
  assign out_link_pc      = link_q;
  assign out_target_pc    = target_q;
  assign out_taken        = taken_q;
  assign out_flush        = flush_q;
  assign out_update_ghsr  = upd_q;
  assign out_ghsr_restore = restore_q;
  assign tag_err          = tag_err_q;

endmodule

// File: tb/tb_bju_ckpt.sv
// Directed self-checking bench for bju_ckpt with hand-computed expectations.
module tb_bju_ckpt;
  import bju_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alloc_valid;
  logic [7:0]  alloc_ghsr;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic        flush_valid;
  control_type control;
  logic [31:0] left_operand, right_operand, pc, immediate_data;
  logic        pred_taken, pred_btb_hit;
  logic [31:0] pred_btb_addr;
  logic        out_valid;
  logic [31:0] out_link_pc, out_target_pc;
  logic        out_taken, out_flush, out_update_ghsr;
  logic [7:0]  out_ghsr_restore;
  logic        tag_err;
  logic [2:0]  ckpt_count;

  int errors = 0;
  int checks = 0;

  bju_ckpt #(.GHR_W(8), .CKPT_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ghsr(alloc_ghsr),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .flush_valid(flush_valid),
    .control(control), .left_operand(left_operand), .right_operand(right_operand),
    .pc(pc), .immediate_data(immediate_data),
    .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit), .pred_btb_addr(pred_btb_addr),
    .out_valid(out_valid), .out_link_pc(out_link_pc), .out_target_pc(out_target_pc),
    .out_taken(out_taken), .out_flush(out_flush), .out_update_ghsr(out_update_ghsr),
    .out_ghsr_restore(out_ghsr_restore), .tag_err(tag_err), .ckpt_count(ckpt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid = 1'b0; alloc_ghsr = 8'h00;
    res_valid = 1'b0; res_tag = 2'd0; flush_valid = 1'b0;
    control = '0;
    left_operand = 32'd0; right_operand = 32'd0; pc = 32'd0; immediate_data = 32'd0;
    pred_taken = 1'b0; pred_btb_hit = 1'b0; pred_btb_addr = 32'd0;
  endtask

  task automatic alloc(input logic [7:0] g);
    alloc_valid = 1'b1; alloc_ghsr = g;
  endtask

  task automatic resolve(input logic [1:0] tag, input logic br, input logic j, input logic jr,
                         input logic [2:0] f3, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] p, input logic [31:0] imm, input logic pt,
                         input logic hit, input logic [31:0] baddr);
    res_valid = 1'b1; res_tag = tag;
    control.is_branch = br; control.is_jump = j; control.is_jumpr = jr; control.funct3 = f3;
    left_operand = l; right_operand = r; pc = p; immediate_data = imm;
    pred_taken = pt; pred_btb_hit = hit; pred_btb_addr = baddr;
  endtask

  task automatic chk_out(input string t, input logic [31:0] link, input logic [31:0] tgt,
                         input logic tk, input logic fl, input logic up, input logic [7:0] rs);
    chk({t, ".valid"},   32'(out_valid), 32'd1);
    chk({t, ".link"},    out_link_pc, link);
    chk({t, ".target"},  out_target_pc, tgt);
    chk({t, ".taken"},   32'(out_taken), 32'(tk));
    chk({t, ".flush"},   32'(out_flush), 32'(fl));
    chk({t, ".upd"},     32'(out_update_ghsr), 32'(up));
    chk({t, ".restore"}, 32'(out_ghsr_restore), 32'(rs));
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.count", 32'(ckpt_count), 32'd0);
    chk("rst.ready", 32'(alloc_ready), 32'd1);
    chk("rst.tag",   32'(alloc_tag), 32'd0);
    chk("rst.err",   32'(tag_err), 32'd0);
    chk("rst.tgt",   out_target_pc, 32'd0);

    // In-order hit: BEQ 5/5 predicted taken to 0x120
    alloc(8'hA5); tick(); clr();
    chk("hit.count1", 32'(ckpt_count), 32'd1);
    chk("hit.tag1",   32'(alloc_tag), 32'd1);
    resolve(2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 32'h120);
    tick(); clr();
    chk_out("hit", 32'h104, 32'h120, 1'b1, 1'b0, 1'b0, 8'h4B);
    chk("hit.count0", 32'(ckpt_count), 32'd0);
    tick();
    chk("hit.onecycle", 32'(out_valid), 32'd0);

    // Direction miss: BNE equal operands predicted taken, two younger entries
    alloc(8'h3C); tick(); alloc(8'h11); tick(); alloc(8'h22); tick(); clr();
    chk("dir.count3", 32'(ckpt_count), 32'd3);
    resolve(2'd1, 1'b1, 1'b0, 1'b0, 3'b001, 32'd7, 32'd7, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240);
    tick(); clr();
    chk_out("dir", 32'h204, 32'h204, 1'b0, 1'b1, 1'b1, 8'h78);
    chk("dir.count0", 32'(ckpt_count), 32'd0);
    chk("dir.tail",   32'(alloc_tag), 32'd0);

    // JALR target miss
    alloc(8'h11); tick(); clr();
    resolve(2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1001, 32'd0, 32'h300, 32'd4, 1'b1, 1'b1, 32'h2000);
    tick(); clr();
    chk_out("jalr", 32'h304, 32'h1004, 1'b1, 1'b1, 1'b0, 8'h23);
    chk("jalr.count", 32'(ckpt_count), 32'd0);

    // Fill the queue (head=tail=1 at this point)
    alloc(8'h01); tick(); alloc(8'h02); tick(); alloc(8'h03); tick(); alloc(8'h04); tick(); clr();
    chk("full.count", 32'(ckpt_count), 32'd4);
    chk("full.ready", 32'(alloc_ready), 32'd0);
    chk("full.tag",   32'(alloc_tag), 32'd1);
    alloc(8'h55); tick(); clr();
    chk("full.drop.count", 32'(ckpt_count), 32'd4);
    chk("full.drop.tag",   32'(alloc_tag), 32'd1);
    // JAL correct resolve of head together with an allocation
    alloc(8'h05);
    resolve(2'd1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h400, 32'h40, 1'b1, 1'b1, 32'h440);
    tick(); clr();
    chk_out("jal", 32'h404, 32'h440, 1'b1, 1'b0, 1'b0, 8'h03);
    chk("jal.count", 32'(ckpt_count), 32'd4);
    chk("jal.tag",   32'(alloc_tag), 32'd2);

    // Wrong tag
    resolve(2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    chk("wrong.err",   32'(tag_err), 32'd1);
    chk("wrong.valid", 32'(out_valid), 32'd0);
    chk("wrong.count", 32'(ckpt_count), 32'd4);
    tick();
    chk("wrong.err1cyc", 32'(tag_err), 32'd0);

    // BLT vs BLTU on 0xFFFFFFFF vs 1
    resolve(2'd2, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h10, 1'b1, 1'b0, 32'h0);
    tick(); clr();
    chk_out("blt", 32'h504, 32'h510, 1'b1, 1'b0, 1'b1, 8'h05);
    chk("blt.count", 32'(ckpt_count), 32'd3);
    resolve(2'd3, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h10, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    chk_out("bltu", 32'h504, 32'h504, 1'b0, 1'b0, 1'b1, 8'h06);
    chk("bltu.count", 32'(ckpt_count), 32'd2);

    // Flush with resolve and allocation in the same cycle
    alloc(8'h77); flush_valid = 1'b1;
    resolve(2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'h600, 32'h8, 1'b1, 1'b1, 32'h608);
    tick(); clr();
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.err",   32'(tag_err), 32'd0);
    chk("fl.count", 32'(ckpt_count), 32'd0);
    chk("fl.tag",   32'(alloc_tag), 32'd2);

    // Resolve on an empty queue with head-matching tag
    resolve(2'd2, 1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    chk("empty.err",   32'(tag_err), 32'd1);
    chk("empty.count", 32'(ckpt_count), 32'd0);
    chk("empty.valid", 32'(out_valid), 32'd0);

    // Illegal funct3: not taken, pc+4
    alloc(8'h81); tick(); clr();
    resolve(2'd2, 1'b1, 1'b0, 1'b0, 3'b010, 32'd1, 32'd1, 32'h700, 32'h30, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    chk_out("ill", 32'h704, 32'h704, 1'b0, 1'b0, 1'b1, 8'h02);

    // Reset mid-operation with a resolve in the same cycle
    alloc(8'h99); tick(); clr();
    chk("mid.count1", 32'(ckpt_count), 32'd1);
    reset_n = 1'b0;
    resolve(2'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'h800, 32'h4, 1'b1, 1'b0, 32'h0);
    tick(); clr(); reset_n = 1'b1;
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.count", 32'(ckpt_count), 32'd0);
    chk("mid.tag",   32'(alloc_tag), 32'd0);
    chk("mid.ready", 32'(alloc_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
